// File: rtl/lcd12864_bus_reader.sv
// Read-side engine for an ST7920-style 8-bit parallel LCD bus.
// Issues status (rs=0) or data (rs=1) read cycles, with an optional
// busy-poll mode that repeats status reads until BF clears or the poll
// budget runs out. bus_own tells the write sequencer to release the bus.
module lcd12864_bus_reader #(
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_EHIGH   = 12,
  parameter int unsigned T_HOLD    = 4,
  parameter int unsigned MAX_POLLS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] cmd,
  output logic       ready,
  output logic       bus_own,
  output logic       rs,
  output logic       rw,
  output logic       en,
  input  logic [7:0] dat_in,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_busy,
  output logic [6:0] resp_addr,
  output logic       timeout
);

  localparam logic [1:0] CMD_STATUS = 2'b00;
  localparam logic [1:0] CMD_DATA   = 2'b01;
  localparam logic [1:0] CMD_POLL   = 2'b10;

  localparam logic [7:0]  SETUP_LAST = 8'(T_SETUP - 1);
  localparam logic [7:0]  EHIGH_LAST = 8'(T_EHIGH - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(T_HOLD - 1);
  localparam logic [15:0] POLL_LIMIT = 16'(MAX_POLLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EHIGH,
    S_HOLD,
    S_RESP
  } state_t;

  state_t      state, state_next;
  logic [7:0]  phase, phase_next;
  logic [15:0] polls, polls_next;
  logic [1:0]  op, op_next;
  logic [7:0]  sample;
  logic        sample_load;
  logic        resp_load;
  logic        on_bus;

  // Next-state logic: phase timing, poll accounting and poll-repeat decision.
  always_comb begin
    state_next  = state;
    phase_next  = phase;
    polls_next  = polls;
    op_next     = op;
    sample_load = 1'b0;
    resp_load   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          // reserved opcode 11 behaves as a single status read
          op_next    = (cmd == 2'b11) ? CMD_STATUS : cmd;
          polls_next = '0;
          phase_next = '0;
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase == SETUP_LAST) begin
          phase_next = '0;
          state_next = S_EHIGH;
        end else begin
          phase_next = phase + 8'd1;
        end
      end
      S_EHIGH: begin
        if (phase == EHIGH_LAST) begin
          phase_next  = '0;
          sample_load = 1'b1;
          polls_next  = (polls == '1) ? polls : polls + 16'd1;
          state_next  = S_HOLD;
        end else begin
          phase_next = phase + 8'd1;
        end
      end
      S_HOLD: begin
        if (phase == HOLD_LAST) begin
          phase_next = '0;
          if (op == CMD_POLL && sample[7] && polls < POLL_LIMIT) begin
            state_next = S_SETUP;
          end else begin
            resp_load  = 1'b1;
            state_next = S_RESP;
          end
        end else begin
          phase_next = phase + 8'd1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    on_bus = (state_next == S_SETUP) || (state_next == S_EHIGH) ||
             (state_next == S_HOLD);
  end

  // State, counters and registered bus/response outputs (outputs track the
  // state they are entering, so en can never glitch).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= '0;
      polls      <= '0;
      op         <= CMD_STATUS;
      sample     <= '0;
      ready      <= 1'b1;
      bus_own    <= 1'b0;
      rs         <= 1'b0;
      rw         <= 1'b0;
      en         <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_busy  <= 1'b0;
      resp_addr  <= '0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      phase      <= phase_next;
      polls      <= polls_next;
      op         <= op_next;
      ready      <= (state_next == S_IDLE);
      bus_own    <= on_bus;
      rw         <= on_bus;
      rs         <= on_bus && (op_next == CMD_DATA);
      en         <= (state_next == S_EHIGH);
      resp_valid <= resp_load;
      if (sample_load) begin
        sample <= dat_in;
      end
      if (resp_load) begin
        resp_data <= sample;
        resp_busy <= (op != CMD_DATA) ? sample[7] : 1'b0;
        resp_addr <= (op != CMD_DATA) ? sample[6:0] : 7'd0;
        timeout   <= (op == CMD_POLL) && sample[7];
      end
    end
  end

endmodule

// File: tb/tb_lcd12864_bus_reader.sv
// Scoreboard bench for lcd12864_bus_reader: a stimulus process pushes the
// expected response of every request, a bus model feeds dat_in per read,
// and a monitor pops and compares whenever resp_valid is seen.
module tb_lcd12864_bus_reader;

  localparam int unsigned TS  = 4;
  localparam int unsigned TE  = 12;
  localparam int unsigned TH  = 4;
  localparam int unsigned PER = TS + TE + TH;

  typedef struct {
    logic [7:0]  data;
    logic        busy;
    logic [6:0]  addr;
    logic        to;
    int unsigned cyc;
    int unsigned pulses;
    int unsigned en_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd;
  logic [7:0] dat_in;
  logic       req0, req1;

  logic       ready0, bus_own0, rs0, rw0, en0, rv0, busy0, to0;
  logic [7:0] rd0;
  logic [6:0] ra0;
  logic       ready1, bus_own1, rs1, rw1, en1, rv1, busy1, to1;
  logic [7:0] rd1;
  logic [6:0] ra1;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [7:0]  rd_vals[$];

  int unsigned act      = 0;
  int unsigned rd_idx   = 0;
  int unsigned pulses   = 0;
  int unsigned first_en = 0;
  logic        en_prev  = 1'b0;
  logic        en_now;

  logic        pend[2];
  int unsigned pend_cyc[2];
  logic [7:0]  held[2];

  lcd12864_bus_reader dut0 (
    .clk(clk), .rst(rst), .req(req0), .cmd(cmd),
    .ready(ready0), .bus_own(bus_own0), .rs(rs0), .rw(rw0), .en(en0),
    .dat_in(dat_in), .resp_valid(rv0), .resp_data(rd0),
    .resp_busy(busy0), .resp_addr(ra0), .timeout(to0)
  );

  lcd12864_bus_reader #(.MAX_POLLS(3)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .cmd(cmd),
    .ready(ready1), .bus_own(bus_own1), .rs(rs1), .rw(rw1), .en(en1),
    .dat_in(dat_in), .resp_valid(rv1), .resp_data(rd1),
    .resp_busy(busy1), .resp_addr(ra1), .timeout(to1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int unsigned actual, input int unsigned expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h cycle=%0d", name, actual, expected, cyc);
    end
  endtask

  // Byte the LCD returns on read number i of the current operation; the last
  // listed byte repeats if the engine reads further.
  function automatic logic [7:0] val(input int unsigned i);
    if (rd_vals.size() == 0) return 8'h00;
    if (i < rd_vals.size()) return rd_vals[i];
    return rd_vals[rd_vals.size() - 1];
  endfunction

  // Reference: count the reads the operation needs, take the last byte, and
  // derive response fields and timing from the phase lengths.
  function automatic exp_t model(input logic [1:0] c, input int unsigned maxp,
                                 input int unsigned acc);
    exp_t        e;
    int unsigned n;
    logic [7:0]  v;
    logic        status;
    n = 1;
    v = val(0);
    if (c == 2'b10) begin
      while (v[7] && n < maxp) begin
        n++;
        v = val(n - 1);
      end
    end
    status   = (c != 2'b01);
    e.data   = v;
    e.busy   = status ? v[7] : 1'b0;
    e.addr   = status ? v[6:0] : 7'd0;
    e.to     = (c == 2'b10) && v[7];
    e.pulses = n;
    e.cyc    = acc + 1 + n * PER;
    e.en_cyc = acc + 1 + TS;
    return e;
  endfunction

  // LCD bus model: on each new en pulse of the active DUT, present the next byte.
  always @(negedge clk) begin
    en_now = (act == 1) ? en1 : en0;
    if (en_now && !en_prev) begin
      if (pulses == 0) first_en = cyc;
      pulses++;
      dat_in = val(rd_idx);
      rd_idx++;
    end
    en_prev = en_now;
  end

  task automatic mon(input int unsigned i, input logic rv, input logic rdy,
                     input logic own, input logic rwv, input logic env,
                     input logic [7:0] d, input logic b, input logic [6:0] a,
                     input logic t);
    exp_t        e;
    int unsigned sz;
    if (pend[i] && cyc == pend_cyc[i]) begin
      pend[i] = 1'b0;
      chk("ready_after_resp", rdy, 1);
      chk("resp_single_pulse", rv, 0);
      chk("resp_data_hold", d, held[i]);
    end
    if (rv) begin
      sz = (i == 1) ? q1.size() : q0.size();
      chk("resp_expected", sz, 1);
      if (sz > 0) begin
        if (i == 1) e = q1.pop_front();
        else        e = q0.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_data", d, e.data);
        chk("resp_busy", b, e.busy);
        chk("resp_addr", a, e.addr);
        chk("timeout", t, e.to);
        chk("ready_in_resp", rdy, 0);
        chk("bus_own_in_resp", own, 0);
        chk("rw_in_resp", rwv, 0);
        chk("en_in_resp", env, 0);
        chk("en_pulses", pulses, e.pulses);
        chk("en_first_cycle", first_en, e.en_cyc);
        pend[i]     = 1'b1;
        pend_cyc[i] = cyc + 1;
        held[i]     = e.data;
      end
    end
  endtask

  // Monitor: compare every response against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      mon(0, rv0, ready0, bus_own0, rw0, en0, rd0, busy0, ra0, to0);
      mon(1, rv1, ready1, bus_own1, rw1, en1, rd1, busy1, ra1, to1);
    end
  end

  task automatic issue(input int unsigned i, input logic [1:0] c);
    exp_t        e;
    int unsigned guard;
    guard = 0;
    @(negedge clk);
    while (((i == 1) ? ready1 : ready0) != 1'b1 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_req", (i == 1) ? ready1 : ready0, 1);
    act      = i;
    rd_idx   = 0;
    pulses   = 0;
    first_en = 0;
    cmd      = c;
    if (i == 1) req1 = 1'b1;
    else        req0 = 1'b1;
    e = model(c, (i == 1) ? 3 : 1000, cyc);
    if (i == 1) q1.push_back(e);
    else        q0.push_back(e);
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    cmd  = 2'($urandom);
    chk("rs_setup", (i == 1) ? rs1 : rs0, (c == 2'b01) ? 1 : 0);
    chk("rw_setup", (i == 1) ? rw1 : rw0, 1);
    chk("bus_own_setup", (i == 1) ? bus_own1 : bus_own0, 1);
    chk("en_setup", (i == 1) ? en1 : en0, 0);
    chk("ready_setup", (i == 1) ? ready1 : ready0, 0);
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("resp_within_bound", q0.size() + q1.size(), 0);
  endtask

  task automatic gen_vals(input logic [1:0] c);
    int unsigned k;
    rd_vals.delete();
    k = $urandom_range(0, 3);
    repeat (k) rd_vals.push_back(8'($urandom) | 8'h80);
    rd_vals.push_back(8'($urandom) & 8'h7F);
    if (c != 2'b10) rd_vals[0] = 8'($urandom);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got=timeout expected=finish cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned inst;
    logic [1:0]  c;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    rst    = 1'b1;
    cmd    = 2'b00;
    req0   = 1'b0;
    req1   = 1'b0;
    dat_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready0, 1);
    chk("rst_bus_own", bus_own0, 0);
    chk("rst_rs", rs0, 0);
    chk("rst_rw", rw0, 0);
    chk("rst_en", en0, 0);
    chk("rst_resp_valid", rv0, 0);
    chk("rst_resp_data", rd0, 0);
    chk("rst_timeout", to0, 0);
    chk("rst_ready_b", ready1, 1);
    rst = 1'b0;

    // Single data read, status read, four-read poll, poll timeout.
    rd_vals = '{8'h41};
    issue(0, 2'b01);
    wait_done();
    rd_vals = '{8'h93};
    issue(0, 2'b00);
    wait_done();
    rd_vals = '{8'h80, 8'h80, 8'h80, 8'h05};
    issue(0, 2'b10);
    wait_done();
    rd_vals = '{8'hFF};
    issue(1, 2'b10);
    wait_done();

    // Requests while busy (EHIGH) and in the response cycle are dropped.
    rd_vals = '{8'h5A};
    issue(0, 2'b01);
    repeat (7) @(negedge clk);
    req0 = 1'b1;
    cmd  = 2'b10;
    @(negedge clk);
    req0 = 1'b0;
    n = 0;
    while (!rv0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_extra_op", q0.size(), 0);

    // Reset while en is high aborts the read without a response.
    rd_vals = '{8'hC3};
    issue(0, 2'b01);
    repeat (9) @(negedge clk);
    chk("en_mid_read", en0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_en", en0, 0);
    chk("abort_rw", rw0, 0);
    chk("abort_bus_own", bus_own0, 0);
    chk("abort_ready", ready0, 1);
    chk("abort_resp_valid", rv0, 0);
    q0.delete();
    rst = 1'b0;
    repeat (30) @(negedge clk);
    rd_vals = '{8'h41};
    issue(0, 2'b01);
    wait_done();

    // Randomized operations on both instances.
    repeat (40) begin
      c    = 2'($urandom);
      inst = ($urandom_range(0, 4) == 0) ? 1 : 0;
      gen_vals(c);
      issue(inst, c);
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
